// File: rtl/cnt_pkg.sv
// Shared definitions for the counter run controller: FSM state type and
// default bus widths.
package cnt_pkg;

    localparam int CNT_WIDTH = 4;
    localparam int CNT_RUNW  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } cnt_state_e;

endpackage

// File: rtl/cnt_if.sv
// Connection between the run controller and the up/down counter it drives.
interface cnt_if
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) ();

    logic             load_en;
    logic [WIDTH-1:0] load;
    logic             down;
    logic [WIDTH-1:0] count;
    logic             rollover;

    // Controller side drives the load/direction controls and observes the counter.
    modport master (
        output load_en,
        output load,
        output down,
        input  count,
        input  rollover
    );

    modport slave (
        input  load_en,
        input  load,
        input  down,
        output count,
        output rollover
    );

endinterface

// File: rtl/cnt_sat_tally.sv
// Saturating tally register with synchronous clear, used to count rollovers
// seen during a run.
module cnt_sat_tally
    import cnt_pkg::*;
#(
    parameter int RUNW = CNT_RUNW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    output logic [RUNW-1:0] tally
);

    logic [RUNW-1:0] tally_reg;
    logic            at_max;

    assign at_max = &tally_reg;
    assign tally  = tally_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tally_reg <= '0;
        end else if (inc && !at_max) begin
            tally_reg <= tally_reg + 1'b1;
        end
    end

endmodule

// File: rtl/cnt_ctrl.sv
// Run controller: loads an external up/down counter, lets it free-run for N
// cycles while tallying rollovers, then reports the tally and final count.
module cnt_ctrl
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH,
    parameter int RUNW  = CNT_RUNW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_load,
    input  logic             cmd_down,
    input  logic [RUNW-1:0]  cmd_cycles,
    output logic             done,
    output logic [RUNW-1:0]  roll_cnt,
    output logic [WIDTH-1:0] final_count,
    cnt_if.master            cnt
);

    cnt_state_e       state_reg;
    logic [WIDTH-1:0] load_reg;
    logic             down_reg;
    logic [RUNW-1:0]  cycles_reg;
    logic [RUNW-1:0]  run_reg;
    logic             load_en_reg;
    logic             done_reg;
    logic [WIDTH-1:0] final_reg;
    logic             tally_clr;
    logic             tally_inc;

    // Ready drops combinationally with rst so no command slips in during reset.
    assign cmd_ready = (state_reg == IDLE) && !rst;

    assign cnt.load_en  = load_en_reg;
    assign cnt.load     = load_reg;
    assign cnt.down     = down_reg;
    assign done         = done_reg;
    assign final_count  = final_reg;

    assign tally_clr = (state_reg == LOAD);
    assign tally_inc = (state_reg == RUN) && cnt.rollover;

    cnt_sat_tally #(
        .RUNW (RUNW)
    ) u_tally (
        .clk   (clk),
        .rst   (rst),
        .clr   (tally_clr),
        .inc   (tally_inc),
        .tally (roll_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            load_reg    <= '0;
            down_reg    <= 1'b0;
            cycles_reg  <= '0;
            run_reg     <= '0;
            load_en_reg <= 1'b0;
            done_reg    <= 1'b0;
            final_reg   <= '0;
        end else begin
            load_en_reg <= 1'b0;
            done_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        load_reg    <= cmd_load;
                        down_reg    <= cmd_down;
                        cycles_reg  <= cmd_cycles;
                        load_en_reg <= 1'b1;
                        state_reg   <= LOAD;
                    end
                end
                LOAD: begin
                    run_reg <= cycles_reg;
                    if (cycles_reg == '0) begin
                        done_reg  <= 1'b1;
                        state_reg <= REPORT;
                    end else begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // The last RUN cycle is the one where the counter still reads 1.
                    run_reg <= run_reg - 1'b1;
                    if (run_reg == RUNW'(1)) begin
                        done_reg  <= 1'b1;
                        state_reg <= REPORT;
                    end
                end
                REPORT: begin
                    final_reg <= cnt.count;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
